// File: rtl/mips32_alu_issue.sv
// Execute-stage operand issue register feeding mips32_alu: accepts decoded
// instructions from ID, resolves operands by MEM/WB forwarding and blocks load-use hazards.
module mips32_alu_issue #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          id_valid,
    output logic          id_ready,
    input  logic [3:0]    id_alu_op,
    input  logic [RW-1:0] id_rs_addr,
    input  logic [RW-1:0] id_rt_addr,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [DW-1:0] id_imm,
    input  logic          id_use_imm,
    input  logic [RW-1:0] id_rd_addr,
    input  logic          id_is_load,
    input  logic          mem_wen,
    input  logic [RW-1:0] mem_rd_addr,
    input  logic [DW-1:0] mem_rd_data,
    input  logic          wb_wen,
    input  logic [RW-1:0] wb_rd_addr,
    input  logic [DW-1:0] wb_rd_data,
    output logic          ex_valid,
    input  logic          ex_ready,
    output logic [DW-1:0] A_in,
    output logic [DW-1:0] B_in,
    output logic [3:0]    ALU_op,
    output logic [RW-1:0] ex_rd_addr,
    output logic          ex_is_load
);

    logic          ex_valid_r;
    logic [DW-1:0] a_r;
    logic [DW-1:0] b_r;
    logic [3:0]    op_r;
    logic [RW-1:0] rd_r;
    logic          is_load_r;
    logic          shadow_v_r;
    logic [RW-1:0] shadow_rd_r;

    logic          rs_hz_s;
    logic          rt_hz_s;
    logic          hazard_s;
    logic          ex_fire_s;
    logic          id_fire_s;
    logic          ready_s;
    logic [DW-1:0] a_sel_s;
    logic [DW-1:0] b_sel_s;

    // A source is blocked while a load producing it sits in EX or has just left EX
    // (its data only reaches the WB bus one cycle later).
    function automatic logic src_blocked(
        input logic [RW-1:0] f_src,
        input logic          f_ex_v,
        input logic          f_ex_ld,
        input logic [RW-1:0] f_ex_rd,
        input logic          f_sh_v,
        input logic [RW-1:0] f_sh_rd
    );
        logic hit;
        if (f_src == {RW{1'b0}}) begin
            hit = 1'b0;
        end else begin
            hit = (f_ex_v && f_ex_ld && (f_ex_rd == f_src)) ||
                  (f_sh_v && (f_sh_rd == f_src));
        end
        return hit;
    endfunction

    // Register 0 reads as zero; MEM forwarding wins over WB, then the register file.
    function automatic logic [DW-1:0] fwd_operand(
        input logic [RW-1:0] f_addr,
        input logic [DW-1:0] f_rf_data,
        input logic          f_mem_wen,
        input logic [RW-1:0] f_mem_rd,
        input logic [DW-1:0] f_mem_data,
        input logic          f_wb_wen,
        input logic [RW-1:0] f_wb_rd,
        input logic [DW-1:0] f_wb_data
    );
        logic [DW-1:0] val;
        if (f_addr == {RW{1'b0}}) begin
            val = {DW{1'b0}};
        end else if (f_mem_wen && (f_mem_rd == f_addr)) begin
            val = f_mem_data;
        end else if (f_wb_wen && (f_wb_rd == f_addr)) begin
            val = f_wb_data;
        end else begin
            val = f_rf_data;
        end
        return val;
    endfunction

    // Load-use hazard detection; rt only matters when the immediate is not used.
    always_comb begin
        rs_hz_s = src_blocked(id_rs_addr, ex_valid_r, is_load_r, rd_r, shadow_v_r, shadow_rd_r);
        rt_hz_s = 1'b0;
        if (!id_use_imm) begin
            rt_hz_s = src_blocked(id_rt_addr, ex_valid_r, is_load_r, rd_r, shadow_v_r, shadow_rd_r);
        end else begin
            rt_hz_s = 1'b0;
        end
        hazard_s = rs_hz_s | rt_hz_s;
    end

    // Handshake: accept only when the slot is empty or draining this cycle.
    always_comb begin
        ex_fire_s = ex_valid_r & ex_ready;
        ready_s   = ~reset & ~flush & ~hazard_s & (~ex_valid_r | ex_ready);
        id_fire_s = id_valid & ready_s;
    end

    // Operand selection at capture time.
    always_comb begin
        a_sel_s = fwd_operand(id_rs_addr, id_rs_data, mem_wen, mem_rd_addr, mem_rd_data,
                              wb_wen, wb_rd_addr, wb_rd_data);
        b_sel_s = {DW{1'b0}};
        if (id_use_imm) begin
            b_sel_s = id_imm;
        end else begin
            b_sel_s = fwd_operand(id_rt_addr, id_rt_data, mem_wen, mem_rd_addr, mem_rd_data,
                                  wb_wen, wb_rd_addr, wb_rd_data);
        end
    end

    // Issue register and load shadow; data registers only move on id_fire so
    // a stalled instruction keeps its operands without re-sampling forward buses.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_r  <= 1'b0;
            a_r         <= {DW{1'b0}};
            b_r         <= {DW{1'b0}};
            op_r        <= 4'h0;
            rd_r        <= {RW{1'b0}};
            is_load_r   <= 1'b0;
            shadow_v_r  <= 1'b0;
            shadow_rd_r <= {RW{1'b0}};
        end else if (flush) begin
            ex_valid_r  <= 1'b0;
            shadow_v_r  <= 1'b0;
        end else begin
            shadow_v_r  <= ex_fire_s & is_load_r;
            shadow_rd_r <= rd_r;
            if (id_fire_s) begin
                ex_valid_r <= 1'b1;
                a_r        <= a_sel_s;
                b_r        <= b_sel_s;
                op_r       <= id_alu_op;
                rd_r       <= id_rd_addr;
                is_load_r  <= id_is_load;
            end else if (ex_fire_s) begin
                ex_valid_r <= 1'b0;
            end
        end
    end

    assign id_ready   = ready_s;
    assign ex_valid   = ex_valid_r;
    assign A_in       = a_r;
    assign B_in       = b_r;
    assign ALU_op     = op_r;
    assign ex_rd_addr = rd_r;
    assign ex_is_load = is_load_r;

endmodule

// File: tb/tb_mips32_alu_issue.sv
// Self-checking bench for mips32_alu_issue: directed scenarios with literal
// expectations plus a randomized run against a cycle-level behavioural model.
module tb_mips32_alu_issue;

    localparam int DW = 32;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          reset, flush, id_valid, id_ready;
    logic [3:0]    id_alu_op;
    logic [RW-1:0] id_rs_addr, id_rt_addr, id_rd_addr;
    logic [DW-1:0] id_rs_data, id_rt_data, id_imm;
    logic          id_use_imm, id_is_load;
    logic          mem_wen, wb_wen;
    logic [RW-1:0] mem_rd_addr, wb_rd_addr;
    logic [DW-1:0] mem_rd_data, wb_rd_data;
    logic          ex_valid, ex_ready;
    logic [DW-1:0] A_in, B_in;
    logic [3:0]    ALU_op;
    logic [RW-1:0] ex_rd_addr;
    logic          ex_is_load;

    int checks = 0;
    int failures = 0;

    // model state: the instruction believed to sit in EX, and when a load last left EX
    logic          m_known = 1'b0;
    logic          m_valid;
    logic [DW-1:0] m_a, m_b;
    logic [3:0]    m_op;
    logic [RW-1:0] m_rd;
    logic          m_load;
    int            cyc = 0;
    int            ld_ret_cyc = -10;
    logic [RW-1:0] ld_ret_rd;

    mips32_alu_issue #(.DW(DW), .RW(RW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready), .id_alu_op(id_alu_op),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_use_imm(id_use_imm),
        .id_rd_addr(id_rd_addr), .id_is_load(id_is_load),
        .mem_wen(mem_wen), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .wb_wen(wb_wen), .wb_rd_addr(wb_rd_addr), .wb_rd_data(wb_rd_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .A_in(A_in), .B_in(B_in), .ALU_op(ALU_op),
        .ex_rd_addr(ex_rd_addr), .ex_is_load(ex_is_load)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic blocked(input logic [RW-1:0] src);
        logic in_ex, just_left;
        in_ex     = m_valid && m_load && (m_rd == src);
        just_left = (cyc == ld_ret_cyc + 1) && (ld_ret_rd == src);
        return (src != 5'd0) && (in_ex || just_left);
    endfunction

    function automatic logic model_ready();
        logic hz;
        hz = blocked(id_rs_addr) || (!id_use_imm && blocked(id_rt_addr));
        return !reset && !flush && !hz && (!m_known || !m_valid || ex_ready);
    endfunction

    function automatic logic [DW-1:0] operand(input logic [RW-1:0] addr, input logic [DW-1:0] rf);
        if (addr == 5'd0) return 32'd0;
        if (mem_wen && mem_rd_addr == addr) return mem_rd_data;
        if (wb_wen && wb_rd_addr == addr) return wb_rd_data;
        return rf;
    endfunction

    // Compare at the falling edge, advance the model, then let the rising edge apply inputs.
    task automatic step();
        logic rdy;
        @(negedge clk);
        rdy = model_ready();
        chk("id_ready", id_ready, rdy);
        if (m_known) begin
            chk("ex_valid", ex_valid, m_valid);
            chk("A_in", A_in, m_a);
            chk("B_in", B_in, m_b);
            chk("ALU_op", ALU_op, m_op);
            chk("ex_rd_addr", ex_rd_addr, m_rd);
            chk("ex_is_load", ex_is_load, m_load);
        end
        if (reset) begin
            m_known = 1'b1; m_valid = 1'b0; m_a = '0; m_b = '0;
            m_op = '0; m_rd = '0; m_load = 1'b0; ld_ret_cyc = -10;
        end else if (flush) begin
            m_valid = 1'b0; ld_ret_cyc = -10;
        end else if (m_known) begin
            if (m_valid && ex_ready && m_load) begin
                ld_ret_cyc = cyc; ld_ret_rd = m_rd;
            end
            if (rdy && id_valid) begin
                m_valid = 1'b1;
                m_a     = operand(id_rs_addr, id_rs_data);
                m_b     = id_use_imm ? id_imm : operand(id_rt_addr, id_rt_data);
                m_op    = id_alu_op;
                m_rd    = id_rd_addr;
                m_load  = id_is_load;
            end else if (m_valid && ex_ready) begin
                m_valid = 1'b0;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 1'b0; flush = 1'b0; id_valid = 1'b0; id_alu_op = 4'h0;
        id_rs_addr = '0; id_rt_addr = '0; id_rs_data = '0; id_rt_data = '0;
        id_imm = '0; id_use_imm = 1'b0; id_rd_addr = '0; id_is_load = 1'b0;
        mem_wen = 1'b0; mem_rd_addr = '0; mem_rd_data = '0;
        wb_wen = 1'b0; wb_rd_addr = '0; wb_rd_data = '0; ex_ready = 1'b1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [RW-1:0] rs, input logic [DW-1:0] rsd,
                         input logic [RW-1:0] rt, input logic [DW-1:0] rtd,
                         input logic [RW-1:0] rd, input logic ld);
        id_valid = 1'b1; id_alu_op = op; id_rs_addr = rs; id_rs_data = rsd;
        id_rt_addr = rt; id_rt_data = rtd; id_rd_addr = rd; id_is_load = ld; id_use_imm = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] exp_q[$];
        idle();
        @(posedge clk);
        #1;

        // reset cycle with an instruction presented
        reset = 1'b1;
        issue(4'h2, 5'd3, 32'd5, 5'd4, 32'd7, 5'd10, 1'b0);
        #1 chk("lit_ready_in_reset", id_ready, 1'b0);
        step();
        reset = 1'b0;
        step();
        chk("lit_basic_valid", ex_valid, 1'b1);
        chk("lit_basic_A", A_in, 32'd5);
        chk("lit_basic_B", B_in, 32'd7);
        chk("lit_basic_op", ALU_op, 4'h2);

        // forwarding priority
        issue(4'h1, 5'd8, 32'h99, 5'd2, 32'h3, 5'd12, 1'b0);
        mem_wen = 1'b1; mem_rd_addr = 5'd8; mem_rd_data = 32'h11;
        wb_wen = 1'b1; wb_rd_addr = 5'd8; wb_rd_data = 32'h22;
        step();
        chk("lit_fwd_mem", A_in, 32'h11);
        mem_wen = 1'b0;
        step();
        chk("lit_fwd_wb", A_in, 32'h22);
        id_rs_addr = 5'd0; mem_wen = 1'b1; mem_rd_addr = 5'd0; wb_rd_addr = 5'd0;
        step();
        chk("lit_fwd_zero", A_in, 32'd0);

        // load-use: two held cycles, then capture from WB
        idle();
        issue(4'h0, 5'd1, 32'h100, 5'd2, 32'h200, 5'd9, 1'b1);
        step();
        issue(4'h3, 5'd9, 32'h1234, 5'd2, 32'h200, 5'd11, 1'b0);
        wb_wen = 1'b1; wb_rd_addr = 5'd9; wb_rd_data = 32'hDEAD;
        #1 chk("lit_lu_hold1", id_ready, 1'b0);
        step();
        #1 chk("lit_lu_hold2", id_ready, 1'b0);
        step();
        #1 chk("lit_lu_go", id_ready, 1'b1);
        step();
        chk("lit_lu_A", A_in, 32'hDEAD);

        // immediate form does not depend on rt
        idle();
        issue(4'h0, 5'd1, 32'h100, 5'd2, 32'h200, 5'd9, 1'b1);
        step();
        issue(4'h6, 5'd1, 32'h100, 5'd9, 32'h300, 5'd13, 1'b0);
        id_use_imm = 1'b1; id_imm = 32'h55;
        #1 chk("lit_imm_ready", id_ready, 1'b1);
        step();
        chk("lit_imm_B", B_in, 32'h55);

        // EX stall with forward buses toggling
        issue(4'h7, 5'd3, 32'h77, 5'd5, 32'h88, 5'd14, 1'b0);
        ex_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mem_wen = 1'($urandom_range(0, 1)); mem_rd_addr = 5'($urandom_range(0, 5));
            mem_rd_data = $urandom;
            wb_wen = 1'($urandom_range(0, 1)); wb_rd_addr = 5'($urandom_range(0, 5));
            wb_rd_data = $urandom;
            #1 chk("lit_stall_ready", id_ready, 1'b0);
            step();
            chk("lit_stall_A", A_in, 32'h100);
            chk("lit_stall_B", B_in, 32'h55);
            chk("lit_stall_op", ALU_op, 4'h6);
        end
        mem_wen = 1'b0; wb_wen = 1'b0; ex_ready = 1'b1;
        step();
        chk("lit_release_valid", ex_valid, 1'b1);
        chk("lit_release_A", A_in, 32'h77);

        // flush kills held load and clears the shadow
        issue(4'h0, 5'd1, 32'h1, 5'd2, 32'h2, 5'd12, 1'b1);
        step();
        flush = 1'b1;
        issue(4'h2, 5'd4, 32'h4, 5'd5, 32'h5, 5'd6, 1'b0);
        #1 chk("lit_flush_ready", id_ready, 1'b0);
        step();
        chk("lit_flush_valid", ex_valid, 1'b0);
        flush = 1'b0;
        issue(4'h2, 5'd12, 32'h4C, 5'd5, 32'h5, 5'd6, 1'b0);
        #1 chk("lit_post_flush_ready", id_ready, 1'b1);
        step();
        chk("lit_post_flush_valid", ex_valid, 1'b1);

        // stream of independent instructions, one per cycle
        idle();
        for (int i = 0; i < 10; i++) begin
            logic [DW-1:0] d;
            d = $urandom;
            issue(4'($urandom_range(0, 15)), 5'($urandom_range(1, 31)), d,
                  5'($urandom_range(1, 31)), $urandom, 5'($urandom_range(0, 31)), 1'b0);
            exp_q.push_back(d);
            step();
            chk("stream_valid", ex_valid, 1'b1);
            chk("stream_A", A_in, exp_q.pop_front());
        end

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            reset       = ($urandom_range(0, 63) == 0);
            flush       = ($urandom_range(0, 15) == 0);
            id_valid    = ($urandom_range(0, 3) != 0);
            ex_ready    = ($urandom_range(0, 3) != 0);
            id_alu_op   = 4'($urandom_range(0, 15));
            id_rs_addr  = 5'($urandom_range(0, 3));
            id_rt_addr  = 5'($urandom_range(0, 3));
            id_rd_addr  = 5'($urandom_range(0, 3));
            id_rs_data  = $urandom;
            id_rt_data  = $urandom;
            id_imm      = $urandom;
            id_use_imm  = ($urandom_range(0, 2) == 0);
            id_is_load  = ($urandom_range(0, 2) == 0);
            mem_wen     = 1'($urandom_range(0, 1));
            mem_rd_addr = 5'($urandom_range(0, 3));
            mem_rd_data = $urandom;
            wb_wen      = 1'($urandom_range(0, 1));
            wb_rd_addr  = 5'($urandom_range(0, 3));
            wb_rd_data  = $urandom;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mips32_alu_issue.md
Name: mips32_alu_issue

Overview:
- Execute-stage operand issue register directly upstream of mips32_alu.
- Accepts decoded instructions from ID over a valid/ready handshake and resolves register operands by forwarding from MEM and WB.
- Detects load-use hazards and holds stable A_in/B_in/ALU_op for the ALU for as long as EX stalls.
- Also carries the destination/load tag that the EX/MEM register needs.

Parameters:
- DW, 32, datapath width (A_in/B_in/forward buses).
- RW, 5, register-address width.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-high reset
- flush  input  1  synchronous kill of held and incoming instruction (branch/exception)
- id_valid  input  1  ID presents an instruction
- id_ready  output  1  issue stage can accept this cycle
- id_alu_op  input  4  ALU operation code
- id_rs_addr  input  RW  source register 1
- id_rt_addr  input  RW  source register 2
- id_rs_data  input  DW  register-file read of rs
- id_rt_data  input  DW  register-file read of rt
- id_imm  input  DW  extended immediate
- id_use_imm  input  1  B operand = id_imm instead of rt
- id_rd_addr  input  RW  destination register (0 = no write)
- id_is_load  input  1  instruction is a load
- mem_wen, mem_rd_addr, mem_rd_data  input  1/RW/DW  EX/MEM result forward bus (non-load)
- wb_wen, wb_rd_addr, wb_rd_data  input  1/RW/DW  MEM/WB forward bus
- ex_valid  output  1  A_in/B_in/ALU_op hold a live instruction
- ex_ready  input  1  EX/MEM accepts this cycle
- A_in  output  DW  ALU operand A (registered)
- B_in  output  DW  ALU operand B (registered)
- ALU_op  output  4  ALU opcode (registered)
- ex_rd_addr  output  RW  destination tag, registered
- ex_is_load  output  1  load tag, registered

Behaviour:
- Reset (sync, reset=1 at clk edge):
  - ex_valid, A_in, B_in, ALU_op, ex_rd_addr, ex_is_load and the load shadow are all cleared to 0.
  - id_ready=0 during the reset cycle.
- Fire events:
  - ex_fire = ex_valid & ex_ready.
  - id_fire = id_valid & id_ready.
- Load shadow: 1-cycle register (shadow_v, shadow_rd) set on ex_fire when ex_is_load=1; otherwise cleared each cycle.
- Hazard (combinational, an operand counts only if used: rs always, rt only when id_use_imm=0, address 0 never matches):
  - (a) ex_valid & ex_is_load & ex_rd_addr==src; or
  - (b) shadow_v & shadow_rd==src.
- id_ready = ~reset & ~flush & ~hazard & (~ex_valid | ex_ready).
- Operand selection at capture, per operand:
  - addr==0 → 0.
  - else mem_wen & mem_rd_addr==addr → mem_rd_data.
  - else wb_wen & wb_rd_addr==addr → wb_rd_data.
  - else the id_*_data value.
  - MEM has priority over WB. B_in = id_imm when id_use_imm=1.
- Register update, priority high→low:
  - reset;
  - flush: ex_valid←0, shadow cleared, data regs unchanged;
  - id_fire: load all output regs, ex_valid←1;
  - ex_fire without id_fire: ex_valid←0;
  - else hold.
- Stall stability: while ex_valid & ~ex_ready, A_in/B_in/ALU_op/tags do not change; forward buses are not re-sampled.
- Simultaneous ex_fire and id_fire: back-to-back issue, no bubble, ex_valid stays 1.
- Latency: 1 cycle from id_fire to ex_valid. Throughput: 1 instruction/cycle absent hazards.
- Load-use: dependent instruction immediately after a load is delayed exactly 2 cycles, i.e. one cycle held by (a) and one by (b). It is then captured with the load data from the WB bus.
- Reset or flush mid-stall drops the held instruction; no partial state survives.

Test Plan:
- Reset, then id_valid=1, op=4'b0010, rs=3 (data 5), rt=4 (data 7), no forwards → next cycle ex_valid=1, A_in=5, B_in=7, ALU_op=2; id_ready=0 during reset cycle.
- Forwarding: rs=8, mem_wen=1 mem_rd=8 data=0x11, wb_wen=1 wb_rd=8 data=0x22 → A_in=0x11. Repeat with mem_wen=0 → A_in=0x22. Repeat with rs=0 and both buses addressing 0 → A_in=0.
- Load-use: load rd=9 issued, then dependent rs=9 presented continuously with ex_ready=1 → id_ready low 2 cycles, capture on cycle 3 takes wb_rd_data=0xDEAD into A_in. With id_use_imm=1 and rt=9, rs=1 → no stall.
- Stall: ex_valid=1, ex_ready=0 for 5 cycles while forward buses toggle → A_in/B_in/ALU_op constant, id_ready=0. Release ex_ready with id_valid=1 → new instruction captured the same edge, ex_valid stays 1.
- Flush with id_valid=1 and ex_valid=1 → next cycle ex_valid=0, id_ready=0 during flush cycle, shadow cleared so a following rs==old load rd is accepted immediately.
- Streaming 10 random independent instructions with ex_ready=1 → one issue per cycle, outputs match the ALU-stimulus order exactly.
